// File: rtl/lc3_mem_arbiter.sv
// Single-port arbiter merging the LC3 fetch and data ports onto one memory channel.
// Optional feature: define LC3_ARB_RR_EN for round-robin arbitration on simultaneous requests.
module lc3_mem_arbiter #(
    parameter int unsigned STALL_THRESH = 1000,
    parameter logic [15:0] ABORT_DATA   = 16'hDEAD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instrmem_rd,
    input  logic [15:0] pc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

    localparam logic [15:0] LAST_STALL = 16'(STALL_THRESH - 1);

    state_t      state;
    logic [15:0] stall_cnt;
    logic [15:0] acc_word;
    logic        grant_data;
    logic        acc_done;

`ifdef LC3_ARB_RR_EN
    logic last_data;

    // A conflict goes to whichever port did not win the previous grant.
    assign grant_data = data_req && (!instrmem_rd || !last_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_data <= 1'b0;
        end else if (state == IDLE && (data_req || instrmem_rd)) begin
            last_data <= grant_data;
        end
    end
`else
    assign grant_data = data_req;
`endif

    assign busy     = (state != IDLE);
    assign acc_done = mem_ready || (stall_cnt == LAST_STALL);

    // Writes return zero; an unanswered read returns the abort marker.
    always_comb begin
        acc_word = 16'h0000;
        if (mem_re) begin
            acc_word = mem_ready ? mem_rdata : ABORT_DATA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            stall_cnt      <= 16'h0000;
            mem_addr       <= 16'h0000;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_wdata      <= 16'h0000;
            Instr_dout     <= 16'h0000;
            Data_dout      <= 16'h0000;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state     <= D_ACC;
                        stall_cnt <= 16'h0000;
                        mem_addr  <= Data_addr;
                        mem_re    <= Data_rd;
                        mem_we    <= !Data_rd;
                        mem_wdata <= Data_rd ? 16'h0000 : Data_din;
                    end else if (instrmem_rd) begin
                        state     <= I_ACC;
                        stall_cnt <= 16'h0000;
                        mem_addr  <= pc;
                        mem_re    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_wdata <= 16'h0000;
                    end
                end
                I_ACC, D_ACC: begin
                    if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'h0001;
                    end
                    if (acc_done) begin
                        state          <= RESP;
                        mem_addr       <= 16'h0000;
                        mem_re         <= 1'b0;
                        mem_we         <= 1'b0;
                        mem_wdata      <= 16'h0000;
                        complete_instr <= (state == I_ACC);
                        complete_data  <= (state == D_ACC);
                        Instr_dout     <= (state == I_ACC) ? acc_word : 16'h0000;
                        Data_dout      <= (state == D_ACC) ? acc_word : 16'h0000;
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    complete_instr <= 1'b0;
                    complete_data  <= 1'b0;
                    Instr_dout     <= 16'h0000;
                    Data_dout      <= 16'h0000;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
